// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// funct encodings, sequencer state encoding and small decode helpers.
package mult_div_ctrl_pkg;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    localparam int MULT_DIV_BUS_W = 64;
    localparam int DATA_BUS_W     = 32;

    typedef enum logic [1:0] {
        MDC_IDLE = 2'b00,
        MDC_CALC = 2'b01,
        MDC_FIX  = 2'b10,
        MDC_DONE = 2'b11
    } mdc_state_t;

    // True for the four funct codes this unit executes.
    function automatic logic is_md_funct(input logic [5:0] f);
        logic ok;
        case (f)
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: ok = 1'b1;
            default:                                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // True for the two's-complement variants (MULT, DIV).
    function automatic logic is_signed_funct(input logic [5:0] f);
        logic s;
        case (f)
            FUNCT_MULT, FUNCT_DIV: s = 1'b1;
            default:               s = 1'b0;
        endcase
        return s;
    endfunction

    // True for the divide variants (DIV, DIVU).
    function automatic logic is_div_funct(input logic [5:0] f);
        logic d;
        case (f)
            FUNCT_DIV, FUNCT_DIVU: d = 1'b1;
            default:               d = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mult_div_ctrl_md_iter_step.sv
// One combinational iteration of the shared accumulator datapath.
// Multiply: accumulator holds {partial product, remaining multiplier bits};
//   add the multiplicand to the upper half when the low bit is set, then
//   shift right one place including the carry.
// Divide: accumulator holds {partial remainder, remaining dividend/quotient};
//   shift left, trial-subtract the divisor from the upper half and shift in
//   a quotient 1 when no borrow occurs (restoring division).
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH-1:0] diff_s;
    logic             borrow_s;

    // Compute both candidate next-accumulator values and select by operation.
    always_comb begin
        sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]};
        rem_sh_s = acc[2*WIDTH-1:WIDTH-1];
        diff_s   = rem_sh_s[WIDTH-1:0] - operand;
        borrow_s = (rem_sh_s < {1'b0, operand});
        acc_next = acc;
        if (is_div) begin
            // The true difference always fits WIDTH bits, so the wrapped
            // subtraction above is exact whenever there is no borrow.
            if (borrow_s) begin
                acc_next = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {diff_s, acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            if (acc[0]) begin
                sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
            end else begin
                sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]};
            end
            acc_next = {sum_s, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// HI/LO multiply/divide sequencer for the EX stage.
// Iterative 32-step multiply / restoring divide on magnitudes, followed by a
// single sign-fix cycle and a one-cycle done pulse.
// Build option MULT_FAST_EN: multiplies use a single-cycle combinational
// product and skip the iteration phase; divides are unchanged.
module mult_div_ctrl
    import mult_div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [5:0]         funct,
    input  logic [WIDTH-1:0]   operand_1,
    input  logic [WIDTH-1:0]   operand_2,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ZERO    = {WIDTH{1'b0}};

    mdc_state_t         state_r;
    logic               is_div_r;
    logic               sign_a_r;
    logic               sign_b_r;
    logic [WIDTH-1:0]   mag_a_r;
    logic [WIDTH-1:0]   mag_b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [CNT_W-1:0]   counter_r;
    logic               busy_r;
    logic               done_r;
    logic [2*WIDTH-1:0] result_r;

    logic               req_signed_s;
    logic               sign_a_s;
    logic               sign_b_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH-1:0]   step_operand_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [2*WIDTH-1:0] fix_src_s;
    logic [2*WIDTH-1:0] fixed_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

    // Request decode: operand signs and magnitudes (raw values for unsigned ops).
    always_comb begin
        req_signed_s = is_signed_funct(funct);
        sign_a_s     = req_signed_s & operand_1[WIDTH-1];
        sign_b_s     = req_signed_s & operand_2[WIDTH-1];
        if (sign_a_s) begin
            mag_a_s = (~operand_1) + W_ONE;
        end else begin
            mag_a_s = operand_1;
        end
        if (sign_b_s) begin
            mag_b_s = (~operand_2) + W_ONE;
        end else begin
            mag_b_s = operand_2;
        end
    end

    // Divisor feeds the divide step, multiplicand feeds the multiply step.
    always_comb begin
        if (is_div_r) begin
            step_operand_s = mag_b_r;
        end else begin
            step_operand_s = mag_a_r;
        end
    end

    md_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc_r),
        .is_div   (is_div_r),
        .operand  (step_operand_s),
        .acc_next (acc_next_s)
    );

    // Sign correction of the unsigned magnitude result.
    always_comb begin
`ifdef MULT_FAST_EN
        if (is_div_r) begin
            fix_src_s = acc_r;
        end else begin
            fix_src_s = {W_ZERO, mag_a_r} * {W_ZERO, mag_b_r};
        end
`else
        fix_src_s = acc_r;
`endif
        quot_s  = fix_src_s[WIDTH-1:0];
        rem_s   = fix_src_s[2*WIDTH-1:WIDTH];
        fixed_s = fix_src_s;
        if (is_div_r) begin
            if (sign_a_r ^ sign_b_r) begin
                quot_s = W_ZERO - fix_src_s[WIDTH-1:0];
            end else begin
                quot_s = fix_src_s[WIDTH-1:0];
            end
            if (sign_a_r) begin
                rem_s = W_ZERO - fix_src_s[2*WIDTH-1:WIDTH];
            end else begin
                rem_s = fix_src_s[2*WIDTH-1:WIDTH];
            end
            fixed_s = {rem_s, quot_s};
        end else begin
            if (sign_a_r ^ sign_b_r) begin
                fixed_s = {(2*WIDTH){1'b0}} - fix_src_s;
            end else begin
                fixed_s = fix_src_s;
            end
        end
    end

    // Sequencer FSM with registered busy/done/result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= MDC_IDLE;
            is_div_r  <= 1'b0;
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            mag_a_r   <= {WIDTH{1'b0}};
            mag_b_r   <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            counter_r <= {CNT_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                MDC_IDLE: begin
                    done_r <= 1'b0;
                    if (start && is_md_funct(funct) && !flush) begin
                        is_div_r  <= is_div_funct(funct);
                        sign_a_r  <= sign_a_s;
                        sign_b_r  <= sign_b_s;
                        mag_a_r   <= mag_a_s;
                        mag_b_r   <= mag_b_s;
                        counter_r <= {CNT_W{1'b0}};
                        busy_r    <= 1'b1;
                        if (is_div_funct(funct)) begin
                            acc_r <= {W_ZERO, mag_a_s};
                        end else begin
                            acc_r <= {W_ZERO, mag_b_s};
                        end
`ifdef MULT_FAST_EN
                        if (is_div_funct(funct)) begin
                            state_r <= MDC_CALC;
                        end else begin
                            state_r <= MDC_FIX;
                        end
`else
                        state_r <= MDC_CALC;
`endif
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= MDC_IDLE;
                    end
                end
                MDC_CALC: begin
                    if (flush) begin
                        busy_r  <= 1'b0;
                        state_r <= MDC_IDLE;
                    end else begin
                        acc_r     <= acc_next_s;
                        counter_r <= counter_r + CNT_ONE;
                        if (counter_r == LAST_ITER) begin
                            state_r <= MDC_FIX;
                        end else begin
                            state_r <= MDC_CALC;
                        end
                    end
                end
                MDC_FIX: begin
                    busy_r <= 1'b0;
                    if (flush) begin
                        state_r <= MDC_IDLE;
                    end else begin
                        result_r <= fixed_s;
                        done_r   <= 1'b1;
                        state_r  <= MDC_DONE;
                    end
                end
                MDC_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= MDC_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= MDC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed vector table, hand-written
// flush/reset/back-to-back sequences and randomized ops against an
// arithmetic reference model.
module tb_mult_div_ctrl;
    import mult_div_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int checks;
    int failures;
    int done_pulses;
    logic [63:0] last_exp;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[9];

    mult_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .funct     (funct),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse seen by the bench.
    always @(negedge clk) begin
        if (done === 1'b1) done_pulses = done_pulses + 1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks = checks + 1;
        if (got !== want) begin
            failures = failures + 1;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Reference: plain arithmetic on the operand values.
    function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r, p;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'd0;
        case (f)
            FUNCT_MULTU: res = {32'd0, a} * {32'd0, b};
            FUNCT_MULT: begin
                p = sa * sb;
                res = p;
            end
            FUNCT_DIVU: begin
                if (b == 32'd0) res = {a, 32'hFFFFFFFF};
                else            res = {a % b, a / b};
            end
            FUNCT_DIV: begin
                if (sb == 0) res = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    function automatic int exp_latency(input logic [5:0] f);
        int lat;
        lat = 34;
`ifdef MULT_FAST_EN
        if (f == FUNCT_MULT || f == FUNCT_MULTU) lat = 2;
`endif
        return lat;
    endfunction

    // Issue one op from an IDLE-cycle negedge; returns at the next IDLE negedge.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name, input bit hold);
        int k, lat, busy_cycles, lat_exp;
        bit seen;
        lat_exp = exp_latency(f);
        start = 1'b1;
        funct = f;
        operand_1 = a;
        operand_2 = b;
        @(posedge clk);
        seen = 1'b0;
        busy_cycles = 0;
        lat = 0;
        k = 0;
        while (!seen && k < 60) begin
            @(negedge clk);
            k = k + 1;
            if (done === 1'b1) begin
                seen = 1'b1;
                lat = k;
            end else if (busy === 1'b1) begin
                busy_cycles = busy_cycles + 1;
            end
        end
        if (!seen) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL %s_timeout no done within %0d cycles", name, k);
        end else begin
            check({name, "_latency"}, 64'(lat), 64'(lat_exp));
            check({name, "_result"}, result, exp);
            check({name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
            check({name, "_busy_cycles"}, 64'(busy_cycles), 64'(lat_exp - 1));
        end
        if (!hold) start = 1'b0;
        last_exp = exp;
        @(negedge clk);
    endtask

    initial begin
        int d0;
        logic [5:0] rf;
        logic [31:0] ra, rb;
        logic [5:0] fsel[4];

        checks = 0;
        failures = 0;
        done_pulses = 0;
        last_exp = 64'd0;
        rst_n = 1'b0;
        start = 1'b0;
        funct = 6'd0;
        operand_1 = 32'd0;
        operand_2 = 32'd0;
        flush = 1'b0;
        fsel[0] = FUNCT_MULT;
        fsel[1] = FUNCT_MULTU;
        fsel[2] = FUNCT_DIV;
        fsel[3] = FUNCT_DIVU;

        vecs[0] = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "multu_max"};
        vecs[1] = '{FUNCT_MULT,  32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, "mult_neg3x5"};
        vecs[2] = '{FUNCT_DIV,   32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, "div_neg7by2"};
        vecs[3] = '{FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_min_by_m1"};
        vecs[4] = '{FUNCT_DIVU,  32'h00000064, 32'h00000000, 64'h00000064_FFFFFFFF, "divu_by_zero"};
        vecs[5] = '{FUNCT_DIV,   32'h00000064, 32'h00000000, 64'h00000064_FFFFFFFF, "div_by_zero"};
        vecs[6] = '{FUNCT_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000, "mult_min_sq"};
        vecs[7] = '{FUNCT_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, "mult_m1_sq"};
        vecs[8] = '{FUNCT_DIVU,  32'd1000,     32'd3,        64'h00000001_0000014D, "divu_1000by3"};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_result", result, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, 1'b0);
        end

        // Invalid funct is ignored
        d0 = done_pulses;
        start = 1'b1;
        funct = 6'b100000;
        operand_1 = 32'd5;
        operand_2 = 32'd6;
        repeat (5) @(negedge clk);
        check("bad_funct_busy", {63'd0, busy}, 64'd0);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("bad_funct_no_done", 64'(done_pulses - d0), 64'd0);
        check("bad_funct_result_kept", result, last_exp);

        // Flush in IDLE blocks acceptance
        start = 1'b1;
        funct = FUNCT_MULTU;
        flush = 1'b1;
        @(negedge clk);
        check("idle_flush_busy", {63'd0, busy}, 64'd0);
        start = 1'b0;
        flush = 1'b0;
        repeat (40) @(negedge clk);
        check("idle_flush_no_done", 64'(done_pulses - d0), 64'd0);

        // Flush mid-CALC cancels the divide
        run_op(FUNCT_MULTU, 32'd9, 32'd9, 64'd81, "pre_flush", 1'b0);
        d0 = done_pulses;
        start = 1'b1;
        funct = FUNCT_DIVU;
        operand_1 = 32'd1000;
        operand_2 = 32'd3;
        @(posedge clk);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy_low", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("flush_no_done", 64'(done_pulses - d0), 64'd0);
        check("flush_result_kept", result, last_exp);
        run_op(FUNCT_DIVU, 32'd1000, 32'd3, 64'h00000001_0000014D, "post_flush_divu", 1'b0);

        // Back-to-back with start held through DONE
        d0 = done_pulses;
        run_op(FUNCT_MULTU, 32'd7, 32'd6, 64'h2A, "b2b_first", 1'b1);
        run_op(FUNCT_MULTU, 32'd2, 32'd3, 64'h6, "b2b_second", 1'b0);
        repeat (40) @(negedge clk);
        check("b2b_two_pulses", 64'(done_pulses - d0), 64'd2);

        // Asynchronous reset mid-operation
        start = 1'b1;
        funct = FUNCT_DIVU;
        operand_1 = 32'd77;
        operand_2 = 32'd5;
        @(posedge clk);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("async_reset_busy", {63'd0, busy}, 64'd0);
        check("async_reset_result", result, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        last_exp = 64'd0;
        @(negedge clk);

        // Randomized ops against the reference model
        for (int n = 0; n < 24; n++) begin
            rf = fsel[$urandom_range(0, 3)];
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 300));
            if (rf == FUNCT_DIV && rb == 32'd0) rb = 32'd1;
            run_op(rf, ra, rb, ref_model(rf, ra, rb), $sformatf("rand%0d", n), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
